final_layer_scheduler: RTL and testbench
========================================

# final_layer_scheduler

Sequencer for the binarised final (dense) layer of the MNIST BNN. It captures a 196-bit flattened activation vector on `start` and fetches the 10 class weight rows one at a time from an external weight store. For each class it computes an XNOR-popcount score in CHUNK-bit slices and tracks the running arg-max. It replaces the fully parallel final-layer datapath with a time-multiplexed one, so only one row register and one CHUNK-wide popcount are instantiated.

## Interface
Parameters:
- NUM_INPUTS, 196, activation/weight row width; must be a multiple of CHUNK (elaboration-time check).
- NUM_CLASSES, 10, number of output classes/weight rows.
- CHUNK, 28, bits popcounted per cycle; NUM_INPUTS/CHUNK = 7 accumulate cycles per class.

Ports:
- clock  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- data_in  in  NUM_INPUTS  flattened activations; sampled into an internal register on accepted start.
- weight_rd_en  out  1  weight-store read strobe.
- weight_addr  out  4  class index of the row being read.
- weight_row  in  NUM_INPUTS  row data; valid exactly 1 cycle after weight_rd_en.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- answer  out  4  arg-max class index.
- answer_valid  out  1  one-cycle pulse when answer is updated.

## Operation
- Reset values: state=IDLE, busy=0, weight_rd_en=0, weight_addr=0, answer=0, answer_valid=0, internal class counter, chunk counter, accumulator, best score and best index all 0.
- IDLE: on start=1, register data_in, clear class k=0, best_score=0, best_idx=0, then go to FETCH. start in any other state is ignored. No queueing.
- FETCH (1 cycle): weight_rd_en=1, weight_addr=k. Go to LOAD.
- LOAD (1 cycle): capture weight_row into the row register. Clear the accumulator and chunk counter c=0. Go to ACCUM.
- ACCUM (NUM_INPUTS/CHUNK cycles): acc += popcount(~(act[c*CHUNK +: CHUNK] ^ row[c*CHUNK +: CHUNK])). Increment c. After the last slice go to CMP.
- CMP (1 cycle): if k==0 or acc > best_score, then best_score=acc and best_idx=k. Ties keep the lower index (strict greater-than). If k==NUM_CLASSES-1 go to DONE, else k++ and go to FETCH.
- DONE (1 cycle): answer=best_idx, answer_valid=1. Go to IDLE.
- Width rules: acc and best_score are 8 bits unsigned (max 196, no overflow). The per-slice popcount is 5 bits.
- answer holds its value until the next DONE. It is not cleared by start.
- data_in and weight_row may change freely outside the cycles in which they are sampled.
- reset in any state: immediate return to IDLE with all reset values on the next edge. An in-flight result is discarded and answer_valid is not pulsed.

## Timing
- start accepted at edge 0:
  - busy=1 from cycle 1.
  - FETCH for class k in cycle 1+10k; LOAD in 2+10k; ACCUM in 3+10k..9+10k; CMP in 10+10k.
  - Class 9 CMP in cycle 100. DONE / answer_valid=1 in cycle 101. busy=0 and IDLE in cycle 102.
- Total latency from start to answer_valid: 101 cycles. Minimum start-to-start interval: 102 cycles (start is accepted again in cycle 102).
- weight_rd_en is high for exactly 10 single cycles per inference, with weight_addr = 0..9 in order.
- weight_addr holds its last value while weight_rd_en=0.
- busy is low during IDLE, including the cycle in which start is sampled.

## Test plan
- data_in all ones; weight row 3 all ones; every other row has 100 ones. Required: scores 196 and 100; answer=3; answer_valid pulses exactly once, 101 cycles after start.
- data_in all zeros; all rows all zeros (every score 196). Required: tie resolves to answer=0.
- Row 9 has one more match than all others (e.g. scores 150 vs 149). Required: answer=9. Confirms the final-class compare and the last-slice accumulation (the difference is placed in bits 168..195).
- start re-asserted at cycles 5 and 50 of a run. Required: ignored; the weight_addr sequence 0..9 is undisturbed and exactly one answer_valid pulse occurs.
- reset asserted in cycle 40 of a run. Required: next cycle busy=0, answer=0, weight_rd_en=0. The following start runs a clean 101-cycle inference with the correct answer.
- Two back-to-back inferences (start at cycle 102 after the first) with different data_in. Required: the second answer reflects the new data, and answer holds the first result until the second DONE.

Source files
------------

// File: rtl/final_layer_scheduler.sv
// Time-multiplexed binarised final dense layer: one weight row per class,
// XNOR-popcount in CHUNK-bit slices, running arg-max with lowest-index tie-break.
module final_layer_scheduler #(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK       = 28
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] data_in,
  output logic                  weight_rd_en,
  output logic [3:0]            weight_addr,
  input  logic [NUM_INPUTS-1:0] weight_row,
  output logic                  busy,
  output logic [3:0]            answer,
  output logic                  answer_valid,
  output logic [2:0]            dbg_state
);

  localparam int NUM_SLICES = NUM_INPUTS / CHUNK;
  localparam int CW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int AW = $clog2(NUM_INPUTS + 1);
  localparam int PW = $clog2(CHUNK + 1);

  if ((NUM_INPUTS % CHUNK) != 0 || NUM_CLASSES > 16 || NUM_CLASSES < 1) begin : g_bad_params
    $error("final_layer_scheduler: NUM_INPUTS must be a multiple of CHUNK and NUM_CLASSES in 1..16");
  end

  // Handshake: start is a single-cycle request honoured only when busy is low;
  // weight_row must carry row weight_addr in the cycle after weight_rd_en is high.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ACCUM = 3'd3,
    S_CMP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_n;

  logic [NUM_INPUTS-1:0] act;
  logic [NUM_INPUTS-1:0] row;
  logic [3:0]            k;
  logic [CW-1:0]         c;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         best_score;
  logic [3:0]            best_idx;
  logic [3:0]            addr_q;
  logic [3:0]            answer_q;

  logic                  last_slice;
  logic                  last_class;
  logic                  better;
  logic [CHUNK-1:0]      match;
  logic [PW-1:0]         slice_pc;

  function automatic logic [PW-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + PW'(v[i]);
    return s;
  endfunction

  assign last_slice = (c == CW'(NUM_SLICES - 1));
  assign last_class = (k == 4'(NUM_CLASSES - 1));
  assign better     = (k == 4'd0) || (acc > best_score);
  assign match      = ~(act[c*CHUNK +: CHUNK] ^ row[c*CHUNK +: CHUNK]);
  assign slice_pc   = popcount(match);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_FETCH;
      S_FETCH: state_n = S_LOAD;
      S_LOAD:  state_n = S_ACCUM;
      S_ACCUM: if (last_slice) state_n = S_CMP;
      S_CMP:   state_n = last_class ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    weight_rd_en = (state == S_FETCH);
    busy         = (state != S_IDLE);
    answer_valid = (state == S_DONE);
    weight_addr  = addr_q;
    answer       = answer_q;
    dbg_state    = state;
  end

  // Wide operand registers carry no reset; they are always loaded before use.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && start) act <= data_in;
    if (state == S_LOAD)          row <= weight_row;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k          <= '0;
      c          <= '0;
      acc        <= '0;
      best_score <= '0;
      best_idx   <= '0;
      addr_q     <= '0;
      answer_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k          <= '0;
            best_score <= '0;
            best_idx   <= '0;
            addr_q     <= '0;
          end
        end
        S_LOAD: begin
          acc <= '0;
          c   <= '0;
        end
        S_ACCUM: begin
          acc <= acc + AW'(slice_pc);
          if (!last_slice) c <= c + CW'(1);
        end
        S_CMP: begin
          if (better) begin
            best_score <= acc;
            best_idx   <= k;
          end
          if (last_class) begin
            answer_q <= better ? k : best_idx;
          end else begin
            k      <= k + 4'd1;
            addr_q <= k + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_final_layer_scheduler.sv
// Table-driven bench for final_layer_scheduler with a synchronous weight-store
// model, fetch-order scoreboard and per-inference timing checks.
module tb_final_layer_scheduler;
  localparam int N = 196;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] data_in;
  logic         weight_rd_en;
  logic [3:0]   weight_addr;
  logic [N-1:0] weight_row;
  logic         busy;
  logic [3:0]   answer;
  logic         answer_valid;
  logic [2:0]   dbg_state;

  always #5 clock = ~clock;

  final_layer_scheduler #(.NUM_INPUTS(N), .NUM_CLASSES(10), .CHUNK(28)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .weight_rd_en (weight_rd_en),
    .weight_addr  (weight_addr),
    .weight_row   (weight_row),
    .busy         (busy),
    .answer       (answer),
    .answer_valid (answer_valid),
    .dbg_state    (dbg_state)
  );

  // Weight store: row valid only in the cycle after a read strobe, junk otherwise.
  logic [N-1:0] mem [10];
  logic [223:0] junk;
  always @(posedge clock) begin
    junk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    if (weight_rd_en) weight_row <= mem[weight_addr];
    else              weight_row <= junk[N-1:0];
  end

  typedef struct {
    logic [N-1:0] data;
    logic [N-1:0] base;
    logic [3:0]   sp_idx;
    logic [N-1:0] sp_row;
    logic [3:0]   sp2_idx;
    logic [N-1:0] sp2_row;
    logic [3:0]   exp_ans;
    int           ra;
    int           rb;
    int           rst_cyc;
    int           gap;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  logic [3:0] exp_q [$];
  logic [3:0] prev_ans;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] mask(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic set_vec(input int i, input logic [N-1:0] data, input logic [N-1:0] base,
                         input logic [3:0] sp_idx, input logic [N-1:0] sp_row,
                         input logic [3:0] sp2_idx, input logic [N-1:0] sp2_row,
                         input logic [3:0] exp_ans, input int ra, input int rb,
                         input int rst_cyc, input int gap);
    vecs[i].data = data;       vecs[i].base = base;
    vecs[i].sp_idx = sp_idx;   vecs[i].sp_row = sp_row;
    vecs[i].sp2_idx = sp2_idx; vecs[i].sp2_row = sp2_row;
    vecs[i].exp_ans = exp_ans; vecs[i].ra = ra; vecs[i].rb = rb;
    vecs[i].rst_cyc = rst_cyc; vecs[i].gap = gap;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int n_valid, valid_cyc, busy_bad, hold_bad, addr_bad;
    logic [3:0] last_addr, a;
    bit aborted;
    v = vecs[vi];
    n_valid = 0; valid_cyc = -1; busy_bad = 0; hold_bad = 0; addr_bad = 0;
    aborted = 1'b0;
    for (int r = 0; r < 10; r++) begin
      if (r == int'(v.sp_idx))       mem[r] = v.sp_row;
      else if (r == int'(v.sp2_idx)) mem[r] = v.sp2_row;
      else                           mem[r] = v.base;
    end
    repeat (v.gap) @(negedge clock);
    exp_q.delete();
    for (int r = 0; r < 10; r++) exp_q.push_back(4'(r));
    data_in = v.data;
    start   = 1'b1;
    @(posedge clock);
    last_addr = 4'd0;
    for (int cyc = 1; cyc <= 102; cyc++) begin
      @(negedge clock);
      start   = (cyc == v.ra) || (cyc == v.rb);
      data_in = ~v.data ^ N'($urandom());
      if (v.rst_cyc != 0 && cyc == v.rst_cyc + 1) begin
        reset = 1'b0;
        check("busy after reset", busy, 0);
        check("answer after reset", answer, 0);
        check("weight_rd_en after reset", weight_rd_en, 0);
        check("answer_valid after reset", answer_valid, 0);
        check("no result before reset", n_valid, 0);
        exp_q.delete();
        prev_ans = 4'd0;
        aborted  = 1'b1;
        break;
      end
      if (v.rst_cyc != 0 && cyc == v.rst_cyc) reset = 1'b1;
      if (busy !== (cyc <= 101)) busy_bad++;
      if (weight_rd_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("extra weight_rd_en cycle", cyc, 0);
        end else begin
          a = exp_q.pop_front();
          check("weight_addr", weight_addr, a);
          check("fetch cycle", cyc, 1 + 10 * int'(a));
          last_addr = a;
        end
      end else if (weight_addr !== last_addr) begin
        addr_bad++;
      end
      if (answer_valid === 1'b1) begin
        n_valid++;
        valid_cyc = cyc;
        check("answer at valid", answer, v.exp_ans);
      end else if (cyc <= 100 && answer !== prev_ans) begin
        hold_bad++;
      end
      if (cyc == 2)   check("state LOAD in cycle 2", dbg_state, 2);
      if (cyc == 10)  check("state CMP in cycle 10", dbg_state, 4);
      if (cyc == 102) check("answer held after DONE", answer, v.exp_ans);
    end
    if (!aborted) begin
      check("answer_valid pulses", n_valid, 1);
      check("answer_valid cycle", valid_cyc, 101);
      check("missing fetches", exp_q.size(), 0);
      check("busy profile errors", busy_bad, 0);
      check("answer hold errors", hold_bad, 0);
      check("weight_addr hold errors", addr_bad, 0);
      prev_ans = v.exp_ans;
    end
  endtask

  initial begin
    logic [N-1:0] ones, alt;
    ones = '1;
    for (int i = 0; i < N; i++) alt[i] = i[0];
    set_vec(0, ones, mask(100), 4'd3, ones, 4'd15, '0, 4'd3, 0, 0, 0, 2);
    set_vec(1, '0, '0, 4'd15, '0, 4'd15, '0, 4'd0, 0, 0, 0, 2);
    set_vec(2, ones, mask(149), 4'd9, mask(149) | (ones & ~(ones >> 1)), 4'd15, '0,
            4'd9, 0, 0, 0, 2);
    set_vec(3, alt, alt ^ mask(30), 4'd6, alt ^ mask(3), 4'd15, '0, 4'd6, 5, 50, 0, 2);
    set_vec(4, ones, mask(100), 4'd3, ones, 4'd15, '0, 4'd3, 0, 0, 40, 2);
    set_vec(5, alt, alt ^ mask(5), 4'd2, alt, 4'd7, alt, 4'd2, 0, 0, 0, 2);
    set_vec(6, ~alt, ~alt ^ mask(10), 4'd8, ~alt, 4'd0, ~alt ^ mask(1), 4'd8, 0, 0, 0, 0);

    reset    = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    prev_ans = 4'd0;
    repeat (3) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset weight_rd_en", weight_rd_en, 0);
    check("reset weight_addr", weight_addr, 0);
    check("reset answer", answer, 0);
    check("reset answer_valid", answer_valid, 0);
    check("reset state", dbg_state, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    repeat (3) @(negedge clock);
    check("final idle busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
